// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch sequencer feeding the UART transmitter
// Optional sticky overflow flag (ovf/ovf_clr) enabled by `define UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
`ifdef UART_TX_FIFO_OVF_EN
  input  logic              ovf_clr,
  output logic              ovf,
`endif
  output logic              idle
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_STROBE    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [1:0]        state;
  logic [ADDR_W:0]   level_next;
  logic              push;
  logic              pop;

  assign push = wr_en && !full;
  assign pop  = (state == ST_IDLE) && !empty && tx_ready;
  assign idle = empty && (state == ST_IDLE) && tx_ready;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // full/empty are registered from the next level so they stay aligned with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      full  <= (level_next == (ADDR_W+1)'(DEPTH));
      empty <= (level_next == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            state    <= ST_STROBE;
          end
        end
        ST_STROBE:    state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (!tx_ready) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // A fresh overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else     ovf <= (wr_en && full) || (ovf && !ovf_clr);
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b1;
  logic       idle;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf_clr = 1'b0;
  logic       ovf;
`endif

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int viol_cnt = 0;
  int busy_cycles = 10;
  logic model_en = 1'b0;
  logic [7:0] cap_q [$];

  uart_tx_fifo #(.ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
`ifdef UART_TX_FIFO_OVF_EN
    .ovf_clr  (ovf_clr),
    .ovf      (ovf),
`endif
    .idle     (idle)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) pulse_cnt++;
      if (tx_start === 1'b1 && tx_ready === 1'b0) viol_cnt++;
    end
  end

  // Transmitter model: samples start, drops ready the next cycle, stays busy.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && tx_start === 1'b1) begin
        cap_q.push_back(tx_data);
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (busy_cycles) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  task automatic do_reset(input logic rdy);
    model_en = 1'b0;
    wr_en = 1'b0;
    tx_ready = rdy;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cap_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int n, input int budget, input string name);
    int cyc;
    cyc = 0;
    while (!(cap_q.size() >= n && idle === 1'b1) && cyc < budget) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (cyc >= budget) begin
      failures++;
      $display("FAIL %s drain timeout: got %0d bytes, required %0d", name, cap_q.size(), n);
    end
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got %b exp 1", idle); end
`ifdef UART_TX_FIFO_OVF_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
  endtask

  task automatic test_single_byte;
    int p0;
    do_reset(1'b1);
    p0 = pulse_cnt;
    write_byte(8'hA5);
    checks++; if (empty !== 1'b0 || level !== 5'd1 || tx_start !== 1'b0) begin failures++;
      $display("FAIL single_after_write empty=%b level=%0d tx_start=%b exp 0/1/0", empty, level, tx_start); end
    @(posedge clk); #1;
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin failures++;
      $display("FAIL single_strobe tx_start=%b tx_data=%h exp 1/a5", tx_start, tx_data); end
    checks++; if (level !== 5'd0 || empty !== 1'b1) begin failures++;
      $display("FAIL single_level level=%0d empty=%b exp 0/1", level, empty); end
    @(posedge clk); #1;
    tx_ready = 1'b0;
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_pulse_width tx_start=%b exp 0", tx_start); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL single_busy_idle idle=%b exp 0", idle); end
    tx_ready = 1'b1;
    #1;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle idle=%b exp 1", idle); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (pulse_cnt - p0 !== 1) begin failures++;
      $display("FAIL single_pulse_count got %0d exp 1", pulse_cnt - p0); end
  endtask

  task automatic test_burst_order;
    int v0;
    do_reset(1'b1);
    busy_cycles = 10;
    model_en = 1'b1;
    v0 = viol_cnt;
    wr_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_data = 8'(i);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    wait_drain(5, 500, "burst");
    checks++; if (cap_q.size() !== 5) begin failures++; $display("FAIL burst_count got %0d exp 5", cap_q.size()); end
    for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== 8'(i + 1)) begin failures++;
        $display("FAIL burst_byte[%0d] got %h exp %h", i, cap_q[i], 8'(i + 1)); end
    end
    checks++; if (viol_cnt !== v0) begin failures++;
      $display("FAIL burst_start_while_busy got %0d exp 0", viol_cnt - v0); end
  endtask

  task automatic test_full_overflow;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i));
    checks++; if (full !== 1'b1 || level !== 5'd16) begin failures++;
      $display("FAIL full_at_16 full=%b level=%0d exp 1/16", full, level); end
    write_byte(8'h20);
    checks++; if (full !== 1'b1 || level !== 5'd16) begin failures++;
      $display("FAIL full_drop full=%b level=%0d exp 1/16", full, level); end
`ifdef UART_TX_FIFO_OVF_EN
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got %b exp 1", ovf); end
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'h21;
    @(posedge clk); #1;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_clr_vs_ovf got %b exp 1", ovf); end
    wr_en = 1'b0;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b exp 0", ovf); end
`endif
    busy_cycles = 3;
    model_en = 1'b1;
    tx_ready = 1'b1;
    wait_drain(16, 1000, "full");
    repeat (10) @(posedge clk);
    #1;
    checks++; if (cap_q.size() !== 16) begin failures++; $display("FAIL full_count got %0d exp 16", cap_q.size()); end
    for (int i = 0; i < 16 && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== 8'(8'h10 + i)) begin failures++;
        $display("FAIL full_byte[%0d] got %h exp %h", i, cap_q[i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_wrap;
    do_reset(1'b1);
    busy_cycles = 2;
    model_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) write_byte(8'(8'h50 + r * 12 + i));
      wait_drain((r + 1) * 12, 1000, "wrap");
    end
    checks++; if (cap_q.size() !== 36) begin failures++; $display("FAIL wrap_count got %0d exp 36", cap_q.size()); end
    for (int i = 0; i < 36 && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== 8'(8'h50 + i)) begin failures++;
        $display("FAIL wrap_byte[%0d] got %h exp %h", i, cap_q[i], 8'(8'h50 + i)); end
    end
  endtask

  task automatic test_push_pop;
    do_reset(1'b0);
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    checks++; if (level !== 5'd3) begin failures++; $display("FAIL pp_level_before got %0d exp 3", level); end
    tx_ready = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h34;
    @(posedge clk); #1;
    wr_en = 1'b0;
    busy_cycles = 3;
    model_en = 1'b1;
    checks++; if (level !== 5'd3 || tx_start !== 1'b1 || tx_data !== 8'h31) begin failures++;
      $display("FAIL pp_same_cycle level=%0d tx_start=%b tx_data=%h exp 3/1/31", level, tx_start, tx_data); end
    wait_drain(4, 500, "push_pop");
    checks++; if (cap_q.size() !== 4) begin failures++; $display("FAIL pp_count got %0d exp 4", cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== 8'(8'h31 + i)) begin failures++;
        $display("FAIL pp_byte[%0d] got %h exp %h", i, cap_q[i], 8'(8'h31 + i)); end
    end
  endtask

  task automatic test_async_reset;
    int p0;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) write_byte(8'(8'h41 + i));
    tx_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx_start !== 1'b1 || level !== 5'd4) begin failures++;
      $display("FAIL ar_strobe tx_start=%b level=%0d exp 1/4", tx_start, level); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_start !== 1'b0 || empty !== 1'b1 || level !== 5'd0 || full !== 1'b0) begin failures++;
      $display("FAIL ar_immediate tx_start=%b empty=%b level=%0d full=%b exp 0/1/0/0", tx_start, empty, level, full); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL ar_tx_data got %h exp 00", tx_data); end
    #1 rst = 1'b0;
    p0 = pulse_cnt;
    busy_cycles = 3;
    model_en = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (pulse_cnt !== p0 || idle !== 1'b1) begin failures++;
      $display("FAIL ar_no_stale pulses=%0d idle=%b exp 0/1", pulse_cnt - p0, idle); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst_order();
    test_full_overflow();
    test_wrap();
    test_push_pop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
